rf_bypass_scoreboard: RTL
=========================

Name: rf_bypass_scoreboard

Overview:
Parametrised multi-read-port register file for the processor datapath, replacing the fixed 32x32 dual-read file. Reads are synchronous with one-cycle latency, and a write in the same cycle is forwarded to the read data. Register 0 can be hardwired to zero. An integrated scoreboard tracks registers with outstanding multi-cycle writes (e.g. loads) and reports per-port busy status so the control unit can stall.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address width
DEPTH, 2**ADDR_WIDTH, number of registers (must be <= 2**ADDR_WIDTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and reserves

Ports:
CLK  in  1  clock, rising-edge active
RST  in  1  reset, asynchronous, active-low
READ  in  1  read enable, applies to all ports
ADDR_R  in  NUM_RD*ADDR_WIDTH  read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH]
DATA_R  out  NUM_RD*DATA_WIDTH  registered read data, packed the same way
RVALID  out  1  high for one cycle when DATA_R holds data from a READ
WRITE  in  1  write enable
ADDR_W  in  ADDR_WIDTH  write address
DATA_W  in  DATA_WIDTH  write data
RESERVE  in  1  mark ADDR_RSV as having a pending write
ADDR_RSV  in  ADDR_WIDTH  register to reserve
BUSY_R  out  NUM_RD  combinational; bit p = pending bit of ADDR_R port p
BUSY_W  out  1  combinational; pending bit of ADDR_RSV (double-reserve check)

Behaviour:
- Reset (RST=0, async): all registers = 0, all pending bits = 0, DATA_R = 0, RVALID = 0. Reset mid-operation discards any in-flight read and write.
- Write: on a rising edge with WRITE=1 and RST=1, mem[ADDR_W] <= DATA_W.
  - Ignored if ADDR_W >= DEPTH.
  - Ignored if ZERO_REG=1 and ADDR_W=0.
- Read: on a rising edge with READ=1, each port's DATA_R <= mem[ADDR_R], and RVALID <= 1. Latency is 1 cycle.
- Read hold: with READ=0, DATA_R holds its previous value and RVALID <= 0. Outputs are never high-Z.
- READ and WRITE are independent and may both be 1 in the same cycle.
- Bypass: if READ=1, WRITE=1 and ADDR_R(p) = ADDR_W (valid, writable address), port p captures DATA_W, not the old contents.
- Zero and out-of-range reads:
  - ZERO_REG=1: a read of address 0 returns 0, including when forwarding would apply.
  - ADDR_R >= DEPTH returns 0.
- Scoreboard (pending bit per register):
  - RESERVE=1 sets pending[ADDR_RSV] at the edge.
  - WRITE=1 clears pending[ADDR_W] at the edge.
  - RESERVE and WRITE to the same address in the same cycle: the data is written and pending ends set (reserve wins; a new load is outstanding).
  - Reserve of register 0 with ZERO_REG=1, or of an address >= DEPTH, is ignored.
  - BUSY_R and BUSY_W reflect current pending state combinationally. They do not look ahead to a same-cycle write.
- A write to a non-pending register is legal and leaves pending = 0.
- Multiple ports reading the same address all return identical data.

Decomposition:
- Package rf_pkg: default DATA_WIDTH and ADDR_WIDTH constants, the zero-word constant, and a function for the port-slice index.
- Sub-module rf_scoreboard (DEPTH, ADDR_WIDTH, ZERO_REG) owns the pending vector, the set/clear priority and the busy lookups.
- Storage array, bypass muxes and output registers stay in the top module, built with a generate loop over NUM_RD.

Test Plan:
- Reset then read: pulse RST=0 while DATA_R=0xDEADBEEF; read regs 5 and 31 -> DATA_R=0 for both, RVALID=1 one cycle after READ.
- Write then read: write 0x12345678 to r7; next cycle READ with ADDR_R0=7 -> DATA_R port0=0x12345678 one cycle later; with READ=0 the following cycle, data is held and RVALID=0.
- Same-cycle bypass: r3=0x1, then in one cycle WRITE r3=0xA5A5A5A5 with READ ADDR_R0=3, ADDR_R1=3 -> both ports return 0xA5A5A5A5.
- Zero register: write 0xFFFFFFFF to r0 and RESERVE r0 -> a read of r0 returns 0 and BUSY_R=0; with ZERO_REG=0, the same read returns 0xFFFFFFFF.
- Scoreboard sequence:
  - RESERVE r9 -> BUSY_R for ADDR_R0=9 is 1 next cycle.
  - WRITE r9 -> busy clears.
  - Simultaneous RESERVE r9 and WRITE r9=0x55 -> r9 reads 0x55 and busy stays 1.
- Async reset mid-operation: assert RST=0 between clock edges during READ and WRITE -> outputs go to 0 immediately, and the in-flight write to r12 is not stored (a later read of r12 returns 0).

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_pkg : shared defaults and slicing helper for the register file        |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package rf_pkg;

  localparam int c_data_width = 32;
  localparam int c_addr_width = 5;

  localparam logic [c_data_width-1:0] c_zero_word = '0;

  // Low bit of port p inside a packed multi-port bus of WIDTH-bit fields.
  function automatic int rd_slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_scoreboard : pending-write bit per register with busy lookups         |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int NUM_RD     = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         set_en,
  input  logic [ADDR_WIDTH-1:0]        set_addr,
  input  logic                         clr_en,
  input  logic [ADDR_WIDTH-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD-1:0]            busy_r,
  output logic                         busy_w
);

  logic [DEPTH-1:0] r_pending;
  logic [DEPTH-1:0] w_pending_nxt;

  // Set is applied after clear so a same-cycle reserve leaves the bit pending.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en && (clr_addr == ADDR_WIDTH'(i))) w_pending_nxt[i] = 1'b0;
      if (set_en && (set_addr == ADDR_WIDTH'(i))) w_pending_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_pending <= '0;
    else      r_pending <= w_pending_nxt;
  end

  always_comb begin
    busy_w = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (set_addr == ADDR_WIDTH'(i)) busy_w = r_pending[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
    localparam int c_lo = rd_slice_lo(p, ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_busy;

    assign w_addr = rd_addr[c_lo +: ADDR_WIDTH];

    always_comb begin
      w_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        if (w_addr == ADDR_WIDTH'(i)) w_busy = r_pending[i];
    end

    assign busy_r[p] = w_busy;
  end

endmodule
`default_nettype wire

// File: rtl/rf_bypass_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rf_bypass_scoreboard : multi-read-port register file, write forwarding   |
// | and pending-write scoreboard.            Rev 1.0 : initial release       |
// +--------------------------------------------------------------------------+
module rf_bypass_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int ADDR_WIDTH = c_addr_width,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         READ,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ADDR_R,
  output logic [NUM_RD*DATA_WIDTH-1:0] DATA_R,
  output logic                         RVALID,
  input  logic                         WRITE,
  input  logic [ADDR_WIDTH-1:0]        ADDR_W,
  input  logic [DATA_WIDTH-1:0]        DATA_W,
  input  logic                         RESERVE,
  input  logic [ADDR_WIDTH-1:0]        ADDR_RSV,
  output logic [NUM_RD-1:0]            BUSY_R,
  output logic                         BUSY_W
);

  localparam logic [DATA_WIDTH-1:0] c_zero = DATA_WIDTH'(c_zero_word);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rvalid;
  logic                  w_wr_en;

  // Register 0 is never stored to, so it also never forwards.
  assign w_wr_en = WRITE && !((ZERO_REG != 0) && (ADDR_W == '0));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= c_zero;
    end else if (w_wr_en) begin
      for (int i = 0; i < DEPTH; i++)
        if (ADDR_W == ADDR_WIDTH'(i)) r_mem[i] <= DATA_W;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_rvalid <= 1'b0;
    else      r_rvalid <= READ;
  end

  assign RVALID = r_rvalid;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    localparam int c_a_lo = rd_slice_lo(p, ADDR_WIDTH);
    localparam int c_d_lo = rd_slice_lo(p, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_addr = ADDR_R[c_a_lo +: ADDR_WIDTH];

    // Only in-range addresses match an entry; anything else reads as zero.
    always_comb begin
      w_rd_data = c_zero;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_addr == ADDR_WIDTH'(i)) begin
          w_rd_data = r_mem[i];
          if (w_wr_en && (ADDR_W == w_addr)) w_rd_data = DATA_W;
        end
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)      r_data <= c_zero;
      else if (READ) r_data <= w_rd_data;
    end

    assign DATA_R[c_d_lo +: DATA_WIDTH] = r_data;
  end

  rf_scoreboard #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG   (ZERO_REG),
    .NUM_RD     (NUM_RD)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .set_en   (RESERVE),
    .set_addr (ADDR_RSV),
    .clr_en   (WRITE),
    .clr_addr (ADDR_W),
    .rd_addr  (ADDR_R),
    .busy_r   (BUSY_R),
    .busy_w   (BUSY_W)
  );

endmodule
`default_nettype wire
